// File: rtl/gtfwizard_raw_multi_init_if.sv
// Channel-vector bundle between the example top / reset helper and gtfwizard_raw_multi_init.
// master drives the per-channel status inputs; slave is the init controller.
interface gtfwizard_raw_multi_init_if #(
  parameter int P_NUM_CH  = 2,
  parameter int P_RETRY_W = 4
);
  logic [P_NUM_CH-1:0]           tx_init_done_in;
  logic [P_NUM_CH-1:0]           rx_init_done_in;
  logic [P_NUM_CH-1:0]           rx_data_good_in;
  logic [P_NUM_CH-1:0]           retry_clr_in;
  logic [P_NUM_CH-1:0]           reset_all_out;
  logic [P_NUM_CH-1:0]           reset_rx_out;
  logic [P_NUM_CH-1:0]           init_done_out;
  logic [P_NUM_CH-1:0]           fail_out;
  logic                          all_init_done_out;
  logic [P_NUM_CH*P_RETRY_W-1:0] retry_ctr_out;

  modport master (
    output tx_init_done_in, rx_init_done_in, rx_data_good_in, retry_clr_in,
    input  reset_all_out, reset_rx_out, init_done_out, fail_out,
           all_init_done_out, retry_ctr_out
  );

  modport slave (
    input  tx_init_done_in, rx_init_done_in, rx_data_good_in, retry_clr_in,
    output reset_all_out, reset_rx_out, init_done_out, fail_out,
           all_init_done_out, retry_ctr_out
  );
endinterface

// File: rtl/gtfwizard_raw_multi_init.sv
// N-channel GTF bring-up controller: independent TX/RX qualification FSM per channel with bounded retry.
// Define GTF_INIT_LOSS_FILTER_EN to require P_LOSS_FILTER_CYC consecutive bad cycles before a MONITOR retry.
module gtfwizard_raw_multi_init #(
  parameter int P_NUM_CH          = 2,
  parameter int P_TX_TIMER_CYC    = 6000000,
  parameter int P_RX_TIMER_CYC    = 26000000,
  parameter int P_RST_PULSE_CYC   = 8,
  parameter int P_RETRY_W         = 4,
  parameter int P_MAX_RETRY       = 0,
  parameter int P_LOSS_FILTER_CYC = 4
) (
  input  logic                     clk_freerun_in,
  input  logic                     reset_all_n_in,
  gtfwizard_raw_multi_init_if.slave bus
);

  localparam int TMR_CYC = (P_TX_TIMER_CYC > P_RX_TIMER_CYC) ? P_TX_TIMER_CYC : P_RX_TIMER_CYC;
  localparam int TMR_W   = $clog2(TMR_CYC);
  localparam int PLS_W   = $clog2(P_RST_PULSE_CYC + 1);

  localparam logic [TMR_W-1:0]     TMR_TERM  = TMR_W'(TMR_CYC - 1);
  localparam logic [TMR_W-1:0]     TX_LAST   = TMR_W'(P_TX_TIMER_CYC - 1);
  localparam logic [TMR_W-1:0]     RX_LAST   = TMR_W'(P_RX_TIMER_CYC - 1);
  localparam logic [PLS_W-1:0]     PLS_LAST  = PLS_W'(P_RST_PULSE_CYC - 1);
  localparam logic [P_RETRY_W-1:0] RETRY_SAT = {P_RETRY_W{1'b1}};
  localparam logic [P_RETRY_W-1:0] MAX_R     = P_RETRY_W'(P_MAX_RETRY);

  if (P_NUM_CH < 1 || P_NUM_CH > 16 || P_TX_TIMER_CYC < 2 || P_RX_TIMER_CYC < 2 ||
      P_RST_PULSE_CYC < 1 || P_MAX_RETRY < 0 || P_MAX_RETRY > (2**P_RETRY_W) - 1 ||
      P_LOSS_FILTER_CYC < 1) begin : g_bad_param
    $error("gtfwizard_raw_multi_init: parameter out of range");
  end

  typedef enum logic [2:0] {
    ST_START, ST_TX_WAIT, ST_RX_WAIT, ST_MONITOR, ST_RST_PULSE, ST_FAILED
  } state_t;

  function automatic logic [P_RETRY_W-1:0] retry_inc(input logic [P_RETRY_W-1:0] v);
    return (v == RETRY_SAT) ? v : v + 1'b1;
  endfunction

  function automatic logic [TMR_W-1:0] timer_inc(input logic [TMR_W-1:0] v);
    return (v == TMR_TERM) ? v : v + 1'b1;
  endfunction

  // Reset asserts asynchronously but releases two clocks later, clean to clk_freerun_in.
  logic [1:0] rst_sync;
  logic       rst_n;

  // NOTE: state is written with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_freerun_in or negedge reset_all_n_in) begin
    if (!reset_all_n_in) rst_sync <= '0;
    else                 rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  logic [P_NUM_CH-1:0] good_meta, good_mid, good_sync;

  always_ff @(posedge clk_freerun_in or negedge rst_n) begin
    if (!rst_n) begin
      good_meta <= '0;
      good_mid  <= '0;
      good_sync <= '0;
    end else begin
      good_meta <= bus.rx_data_good_in;
      good_mid  <= good_meta;
      good_sync <= good_mid;
    end
  end

  logic [P_NUM_CH-1:0] done;

  for (genvar ch = 0; ch < P_NUM_CH; ch++) begin : g_ch
    state_t                 state;
    logic [TMR_W-1:0]       timer;
    logic [P_RETRY_W-1:0]   retry;
    logic [PLS_W-1:0]       pulse;
    logic                   rst_all, rst_rx, up, fail;
    logic                   loss, trip, at_limit;

    assign loss = !(bus.rx_init_done_in[ch] && good_sync[ch]);

`ifdef GTF_INIT_LOSS_FILTER_EN
    localparam int               LOSS_W    = $clog2(P_LOSS_FILTER_CYC + 1);
    localparam logic [LOSS_W-1:0] LOSS_LAST = LOSS_W'(P_LOSS_FILTER_CYC - 1);
    logic [LOSS_W-1:0] loss_cnt;

    assign trip = loss && (loss_cnt == LOSS_LAST);

    // Persistence counter only runs inside MONITOR; any good cycle restarts it.
    always_ff @(posedge clk_freerun_in or negedge rst_n) begin
      if (!rst_n)                                    loss_cnt <= '0;
      else if (state == ST_MONITOR && loss && !trip) loss_cnt <= loss_cnt + 1'b1;
      else                                           loss_cnt <= '0;
    end
`else
    assign trip = loss;
`endif

    if (P_MAX_RETRY == 0) begin : g_unlimited
      assign at_limit = 1'b0;
    end else begin : g_limited
      assign at_limit = (retry >= MAX_R);
    end

    always_ff @(posedge clk_freerun_in or negedge rst_n) begin
      if (!rst_n) begin
        state   <= ST_START;
        timer   <= '0;
        retry   <= '0;
        pulse   <= '0;
        rst_all <= 1'b0;
        rst_rx  <= 1'b0;
        up      <= 1'b0;
        fail    <= 1'b0;
      end else begin
        unique case (state)
          ST_START: begin
            timer <= '0;
            state <= ST_TX_WAIT;
          end
          ST_TX_WAIT: begin
            if (bus.tx_init_done_in[ch]) begin
              timer <= '0;
              state <= ST_RX_WAIT;
            end else if (timer == TX_LAST) begin
              rst_all <= 1'b1;
              retry   <= retry_inc(retry);
              pulse   <= '0;
              state   <= ST_RST_PULSE;
            end else begin
              timer <= timer_inc(timer);
            end
          end
          ST_RX_WAIT: begin
            if (timer == RX_LAST) begin
              if (!loss) begin
                up    <= 1'b1;
                state <= ST_MONITOR;
              end else begin
                rst_rx <= 1'b1;
                retry  <= retry_inc(retry);
                pulse  <= '0;
                state  <= ST_RST_PULSE;
              end
            end else begin
              timer <= timer_inc(timer);
            end
          end
          ST_MONITOR: begin
            if (trip) begin
              up     <= 1'b0;
              rst_rx <= 1'b1;
              retry  <= retry_inc(retry);
              pulse  <= '0;
              state  <= ST_RST_PULSE;
            end
          end
          ST_RST_PULSE: begin
            if (pulse == PLS_LAST) begin
              rst_all <= 1'b0;
              rst_rx  <= 1'b0;
              if (at_limit) begin
                fail  <= 1'b1;
                state <= ST_FAILED;
              end else begin
                state <= ST_START;
              end
            end else begin
              pulse <= pulse + 1'b1;
            end
          end
          ST_FAILED: begin
            if (bus.retry_clr_in[ch]) begin
              fail  <= 1'b0;
              state <= ST_START;
            end
          end
          default: state <= ST_START;
        endcase
        // NOTE: the later non-blocking write wins, so a clear overrides any increment above.
        if (bus.retry_clr_in[ch]) retry <= '0;
      end
    end

    assign done[ch]                                    = up;
    assign bus.reset_all_out[ch]                       = rst_all;
    assign bus.reset_rx_out[ch]                        = rst_rx;
    assign bus.fail_out[ch]                            = fail;
    assign bus.retry_ctr_out[ch*P_RETRY_W +: P_RETRY_W] = retry;
  end

  logic all_done;

  always_ff @(posedge clk_freerun_in or negedge rst_n) begin
    if (!rst_n) all_done <= 1'b0;
    else        all_done <= &done;
  end

  assign bus.init_done_out     = done;
  assign bus.all_init_done_out = all_done;

endmodule

// File: tb/tb_gtfwizard_raw_multi_init.sv
// Bench for gtfwizard_raw_multi_init: milestone table, directed corner sequences, random stimulus vs reference model.
// A second instance with unlimited retries checks counter saturation.
module tb_gtfwizard_raw_multi_init;
  localparam int NCH = 2, TXC = 16, RXC = 32, PLS = 4, W = 4, MAXR = 3, LFC = 4;

  logic clk = 1'b0;
  logic rst_n, rst_u_n;
  always #5 clk = ~clk;

  gtfwizard_raw_multi_init_if #(.P_NUM_CH(NCH), .P_RETRY_W(W)) bus ();
  gtfwizard_raw_multi_init_if #(.P_NUM_CH(NCH), .P_RETRY_W(W)) bus_u ();

  gtfwizard_raw_multi_init #(
    .P_NUM_CH(NCH), .P_TX_TIMER_CYC(TXC), .P_RX_TIMER_CYC(RXC), .P_RST_PULSE_CYC(PLS),
    .P_RETRY_W(W), .P_MAX_RETRY(MAXR), .P_LOSS_FILTER_CYC(LFC)
  ) dut (.clk_freerun_in(clk), .reset_all_n_in(rst_n), .bus(bus));

  gtfwizard_raw_multi_init #(
    .P_NUM_CH(NCH), .P_TX_TIMER_CYC(TXC), .P_RX_TIMER_CYC(RXC), .P_RST_PULSE_CYC(PLS),
    .P_RETRY_W(W), .P_MAX_RETRY(0), .P_LOSS_FILTER_CYC(LFC)
  ) dut_u (.clk_freerun_in(clk), .reset_all_n_in(rst_u_n), .bus(bus_u));

  int checks = 0, errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a channel is described by its phase, cycles spent there, and its retry tally.
  typedef enum int {M_IDLE, M_TXW, M_RXW, M_LINK, M_PULSE, M_LOCK} mphase_t;
  mphase_t mp[NCH];
  int      el[NCH], mr[NCH], ml[NCH];
  bit      mk_all[NCH];
  bit      glog[NCH][8];
  bit      m_all;
  int      cyc, rel;

  task automatic model_reset();
    rel = 0; cyc = 0; m_all = 1'b0;
    for (int ch = 0; ch < NCH; ch++) begin
      mp[ch] = M_IDLE; el[ch] = 0; mr[ch] = 0; ml[ch] = 0; mk_all[ch] = 1'b0;
      for (int k = 0; k < 8; k++) glog[ch][k] = 1'b0;
    end
  endtask

  task automatic to_pulse(input int ch, input bit all_kind, inout bit inc);
    mp[ch] = M_PULSE; el[ch] = 0; mk_all[ch] = all_kind; inc = 1'b1;
  endtask

  task automatic model_step();
    bit nxt_all = 1'b1;
    cyc++;
    for (int ch = 0; ch < NCH; ch++) nxt_all &= (mp[ch] == M_LINK);
    for (int ch = 0; ch < NCH; ch++) begin
      bit tx  = bus.tx_init_done_in[ch];
      bit rx  = bus.rx_init_done_in[ch];
      bit clr = bus.retry_clr_in[ch];
      bit gs  = (cyc >= 4) ? glog[ch][(cyc - 3) % 8] : 1'b0;  // data good seen three clocks late
      bit inc = 1'b0;
      bit lost, trip;
      glog[ch][cyc % 8] = bus.rx_data_good_in[ch];
      lost = !(rx && gs);
      case (mp[ch])
        M_IDLE: begin mp[ch] = M_TXW; el[ch] = 0; end
        M_TXW:
          if (tx) begin mp[ch] = M_RXW; el[ch] = 0; end
          else if (el[ch] == TXC - 1) to_pulse(ch, 1'b1, inc);
          else el[ch]++;
        M_RXW:
          if (el[ch] == RXC - 1) begin
            if (!lost) begin mp[ch] = M_LINK; ml[ch] = 0; end
            else to_pulse(ch, 1'b0, inc);
          end else el[ch]++;
        M_LINK: begin
          ml[ch] = lost ? ml[ch] + 1 : 0;
`ifdef GTF_INIT_LOSS_FILTER_EN
          trip = (ml[ch] >= LFC);
`else
          trip = lost;
`endif
          if (trip) to_pulse(ch, 1'b0, inc);
        end
        M_PULSE:
          if (el[ch] == PLS - 1) mp[ch] = (MAXR != 0 && mr[ch] >= MAXR) ? M_LOCK : M_IDLE;
          else el[ch]++;
        M_LOCK: if (clr) mp[ch] = M_IDLE;
        default: ;
      endcase
      if (inc && mr[ch] < (1 << W) - 1) mr[ch]++;
      if (clr) mr[ch] = 0;
    end
    m_all = nxt_all;
  endtask

  function automatic logic [16:0] exp_vec();
    logic [1:0] ra, rr, id, fl;
    logic [7:0] rc;
    for (int ch = 0; ch < NCH; ch++) begin
      ra[ch] = (mp[ch] == M_PULSE) && mk_all[ch];
      rr[ch] = (mp[ch] == M_PULSE) && !mk_all[ch];
      id[ch] = (mp[ch] == M_LINK);
      fl[ch] = (mp[ch] == M_LOCK);
      rc[ch*W +: W] = W'(mr[ch]);
    end
    return {ra, rr, id, fl, rc, m_all};
  endfunction

  function automatic logic [16:0] act_vec();
    return {bus.reset_all_out, bus.reset_rx_out, bus.init_done_out, bus.fail_out,
            bus.retry_ctr_out, bus.all_init_done_out};
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n)       model_reset();
      else if (rel < 2) rel++;          // matches the two-clock reset release
      else              model_step();
    end
  end

  initial forever begin
    @(negedge clk);
    check("model", 32'(act_vec()), 32'(exp_vec()));
  end

  typedef struct packed {
    logic [7:0] edge_no;
    logic [1:0] ra, rr, id, fl;
    logic [7:0] retry;
    logic       all;
  } vec_t;

  vec_t tbl[10];

  task automatic wait_bit(input logic [1:0] sig_sel, input int ch, input int limit, output int n);
    n = 0;
    while (n < limit) begin
      if (sig_sel == 2'd0 && bus.reset_rx_out[ch]) break;
      if (sig_sel == 2'd1 && bus.init_done_out[ch]) break;
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int n, hi;
    // ch0 never completes TX; ch1 has everything good from the start.
    tbl[0] = '{8'd10, 2'b00, 2'b00, 2'b00, 2'b00, 8'h00, 1'b0};
    tbl[1] = '{8'd17, 2'b01, 2'b00, 2'b00, 2'b00, 8'h01, 1'b0};
    tbl[2] = '{8'd20, 2'b01, 2'b00, 2'b00, 2'b00, 8'h01, 1'b0};
    tbl[3] = '{8'd21, 2'b00, 2'b00, 2'b00, 2'b00, 8'h01, 1'b0};
    tbl[4] = '{8'd34, 2'b00, 2'b00, 2'b10, 2'b00, 8'h01, 1'b0};
    tbl[5] = '{8'd38, 2'b01, 2'b00, 2'b10, 2'b00, 8'h02, 1'b0};
    tbl[6] = '{8'd59, 2'b01, 2'b00, 2'b10, 2'b00, 8'h03, 1'b0};
    tbl[7] = '{8'd62, 2'b01, 2'b00, 2'b10, 2'b00, 8'h03, 1'b0};
    tbl[8] = '{8'd63, 2'b00, 2'b00, 2'b10, 2'b01, 8'h03, 1'b0};
    tbl[9] = '{8'd80, 2'b00, 2'b00, 2'b10, 2'b01, 8'h03, 1'b0};

    rst_n = 1'b1; rst_u_n = 1'b1;
    bus.tx_init_done_in = 2'b10; bus.rx_init_done_in = 2'b10;
    bus.rx_data_good_in = 2'b10; bus.retry_clr_in    = 2'b00;
    bus_u.tx_init_done_in = '0; bus_u.rx_init_done_in = '0;
    bus_u.rx_data_good_in = '0; bus_u.retry_clr_in    = '0;
    #1 rst_n = 1'b0; rst_u_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'(act_vec()), 32'h0);
    rst_n = 1'b1; rst_u_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      while (cyc < int'(tbl[i].edge_no)) @(negedge clk);
      check($sformatf("table[%0d]", i), 32'(act_vec()),
            32'({tbl[i].ra, tbl[i].rr, tbl[i].id, tbl[i].fl, tbl[i].retry, tbl[i].all}));
    end

    // Release ch0 from FAILED.
    bus.retry_clr_in = 2'b01;
    @(negedge clk);
    bus.retry_clr_in = 2'b00;
    check("clr_fail", 32'(bus.fail_out[0]), 32'h0);
    check("clr_retry", 32'(bus.retry_ctr_out[3:0]), 32'h0);

    // ch0 bring-up with tx done a few cycles into the wait.
    bus.rx_init_done_in = 2'b11; bus.rx_data_good_in = 2'b11;
    repeat (5) @(negedge clk);
    bus.tx_init_done_in = 2'b11;
    wait_bit(2'd1, 0, 100, n);
    check("ch0_up", 32'(bus.init_done_out[0]), 32'h1);
    check("ch0_up_no_reset", 32'({bus.reset_all_out[0], bus.reset_rx_out[0]}), 32'h0);
    check("all_lag_rise", 32'(bus.all_init_done_out), 32'h0);
    @(negedge clk);
    check("all_set", 32'(bus.all_init_done_out), 32'h1);

`ifdef GTF_INIT_LOSS_FILTER_EN
    bus.rx_data_good_in[1] = 1'b0;
    @(negedge clk);
    bus.rx_data_good_in[1] = 1'b1;
    repeat (12) @(negedge clk);
    check("filter_ignores_glitch", 32'({bus.reset_rx_out[1], bus.init_done_out[1]}), 32'h1);
    bus.rx_data_good_in[1] = 1'b0;
    repeat (LFC) @(negedge clk);
    bus.rx_data_good_in[1] = 1'b1;
`else
    bus.rx_data_good_in[1] = 1'b0;
    @(negedge clk);
    bus.rx_data_good_in[1] = 1'b1;
`endif
    wait_bit(2'd0, 1, 12, n);
    check("loss_reset_rx", 32'(bus.reset_rx_out[1]), 32'h1);
    check("loss_init_done", 32'(bus.init_done_out[1]), 32'h0);
    check("loss_retry", 32'(bus.retry_ctr_out[7:4]), 32'h1);
    check("loss_no_reset_all", 32'(bus.reset_all_out[1]), 32'h0);
    check("all_lag_fall", 32'(bus.all_init_done_out), 32'h1);
    hi = 1;
    @(negedge clk);
    check("all_clr", 32'(bus.all_init_done_out), 32'h0);
    while (bus.reset_rx_out[1] && hi < 10) begin
      hi++;
      @(negedge clk);
    end
    check("pulse_len", 32'(hi), 32'd4);

    // Reset asserted while ch0 is mid reset pulse clears everything at once.
    bus.rx_init_done_in[0] = 1'b0;
    wait_bit(2'd0, 0, 12, n);
    bus.rx_init_done_in[0] = 1'b1;
    @(negedge clk);
    check("pulse_before_reset", 32'(bus.reset_rx_out[0]), 32'h1);
    #1 rst_n = 1'b0;
    #1 check("async_reset", 32'(act_vec()), 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      for (int ch = 0; ch < NCH; ch++) begin
        bus.tx_init_done_in[ch] = ($urandom_range(0, 15) == 0);
        bus.rx_init_done_in[ch] = ($urandom_range(0, 39) != 0);
        bus.rx_data_good_in[ch] = ($urandom_range(0, 29) != 0);
        bus.retry_clr_in[ch]    = ($urandom_range(0, 59) == 0);
      end
    end

    check("unlimited_saturate", 32'(bus_u.retry_ctr_out), 32'hff);
    check("unlimited_never_fail", 32'(bus_u.fail_out), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
